uart_tx_arbiter: RTL
====================

# uart_tx_arbiter

Round-robin arbiter that shares the single 32-bit word UART transmitter (four bytes per word, LSB byte first) among up to NREQ requesters, e.g. the core's debug dump, the register-file dump and the testbench-visible status port. It picks one pending requester and latches that requester's word. It issues a one-cycle start pulse to the word transmitter, then holds the word stable until the transmitter signals word end. Finally it reports acceptance and completion back to the winning requester. It sits between the requesters and the word transmitter. The word transmitter's interface is unchanged.

## Interface
- NREQ, 4: number of requesters; legal range 2..8.
- IDW, derived: $clog2(NREQ), the width of grant_id.
- clk  in  1  system clock; all logic is rising-edge.
- reset  in  1  synchronous, active-high reset.
- req  in  NREQ  per-requester request level; bit i is sampled only while the arbiter is IDLE.
- req_data  in  32*NREQ  requester i's word is bits [32*i+31:32*i]; it is sampled only on the grant edge.
- ack  out  NREQ  one-hot, one-cycle pulse: requester's word has been latched.
- done  out  NREQ  one-hot, one-cycle pulse: requester's word has been fully transmitted.
- grant_id  out  IDW  index of the current or most recent winner.
- busy  out  1  high while a word is owned (START or WAIT).
- word_start  out  1  one-cycle start pulse to the word transmitter's send_start.
- word_data  out  32  latched word, driven to the word transmitter's data_in.
- word_end  in  1  the word transmitter's data_end; a one-cycle completion pulse.

## Operation
- States:
  - IDLE: no word owned.
  - START: word_start is asserted.
  - WAIT: waiting for word_end.
- IDLE transition: if req != 0, choose the winner g, then go to START. Otherwise stay in IDLE.
- Winner selection: the first set bit of req, scanning cyclically from last+1 through last+NREQ (mod NREQ).
- Grant-edge actions:
  - word_data <= req_data slice g.
  - grant_id <= g.
  - last <= g.
  - ack[g] <= 1.
- START: always go to WAIT after one cycle.
- WAIT: stay until word_end = 1, then set done[grant_id] <= 1 and go to IDLE.
- word_end outside WAIT is ignored. No done is produced for it.
- req is a level:
  - A requester still holding req when the arbiter returns to IDLE is treated as a new request.
  - Requesters drop req on or after ack.
  - Round-robin prevents a holding requester from starving the others.
- req and req_data changes during START or WAIT have no effect.
- word_data is stable from the grant edge until the next grant edge. This satisfies the word transmitter's requirement that data_in be held for the whole word.
- All outputs are registered.
- Reset values:
  - State IDLE.
  - ack, done and word_start = 0.
  - busy = 0.
  - word_data = 0.
  - grant_id = 0.
  - last = NREQ-1, so requester 0 wins first.
- Reset mid-word: the arbiter returns to IDLE immediately. No done is issued. The word transmitter shares the same reset, so both restart together.

## Timing
- Grant latency: with req seen in IDLE at cycle t, ack[g], word_start, busy and the new word_data are all high or valid at cycle t+1.
- START occupies exactly one cycle (t+1). WAIT begins at t+2.
- The word transmitter leaves its IDLE at t+2 on seeing word_start.
- Completion: with word_end seen in WAIT at cycle u:
  - done[g] is pulsed at u+1.
  - busy is low at u+1.
  - The arbiter is in IDLE at u+1 and can grant at u+1, so the next word_start is at u+2.
- Back-to-back words have a 2-cycle gap between word_end and the next word_start. This matches the word transmitter's one-cycle DONE followed by IDLE.
- ack and done never occur in the same cycle for the same requester.
- At most one ack bit and at most one done bit is set in any cycle.

## Test plan
- Reset, then idle: all outputs 0 and grant_id = 0. With req = 0 for 50 cycles, no word_start pulse occurs.
- Single request: req = 4'b0100 with slice 2 = 32'hDEADBEEF.
  - Next cycle: ack = 4'b0100, word_start = 1, word_data = 32'hDEADBEEF, grant_id = 2.
  - A word_end pulse arriving in WAIT gives done = 4'b0100 one cycle later.
  - The transmitted bytes are EF, BE, AD, DE.
- Fairness: req = 4'b1111 held continuously after reset.
  - Grants occur in order 0, 1, 2, 3, 0.
  - Each word_start comes 2 cycles after the previous word_end.
- Data hold: change req_data slice g to 32'h0 in the cycle after ack. word_data stays at the latched value until done.
- Stray word_end: pulse word_end while IDLE and again during START. No done occurs, and the state sequence is unaffected.
- Reset mid-word: assert reset during WAIT. The next cycle has busy = 0, no done, and last = NREQ-1. The next request from requester 0 is granted first.

Source files
------------

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter
//   Round-robin arbiter that shares one 32-bit word UART transmitter among
//   NREQ requesters. It grants one pending requester, latches its word,
//   pulses word_start for one cycle and holds word_data until word_end.
//   Each grant is reported with ack and each completion with done.
//
// Ports
//   clk        : system clock, rising edge
//   reset      : synchronous, active-high reset
//   req        : per-requester request level (sampled only in IDLE)
//   req_data   : requester i's word in bits [32*i+31:32*i] (sampled on grant)
//   ack        : one-hot one-cycle pulse, word latched
//   done       : one-hot one-cycle pulse, word fully transmitted
//   grant_id   : index of the current or most recent winner
//   busy       : high while a word is owned (START or WAIT)
//   word_start : one-cycle start pulse to the transmitter
//   word_data  : latched word to the transmitter's data input
//   word_end   : transmitter completion pulse (honoured only in WAIT)
module uart_tx_arbiter #(
  parameter int NREQ = 4,
  localparam int IDW = $clog2(NREQ)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NREQ-1:0]      req,
  input  logic [32*NREQ-1:0]   req_data,
  output logic [NREQ-1:0]      ack,
  output logic [NREQ-1:0]      done,
  output logic [IDW-1:0]       grant_id,
  output logic                 busy,
  output logic                 word_start,
  output logic [31:0]          word_data,
  input  logic                 word_end
);

  localparam int unsigned NREQ_U = NREQ;

  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_WAIT
  } state_t;

  state_t           state, state_n;
  logic [IDW-1:0]   last;
  logic [IDW-1:0]   win;
  logic [IDW-1:0]   idx;
  logic             found;
  logic [NREQ-1:0]  ack_n;
  logic [NREQ-1:0]  done_n;
  logic             start_n;

  // Next-state and next-output decode. The winner scan starts just after
  // the previous winner so a requester holding req cannot starve others.
  always_comb begin
    state_n = state;
    win     = '0;
    idx     = '0;
    found   = 1'b0;
    ack_n   = '0;
    done_n  = '0;
    start_n = 1'b0;

    for (int unsigned k = 1; k <= NREQ_U; k++) begin
      idx = IDW'((32'(last) + k) % NREQ_U);
      if (!found && req[idx]) begin
        win   = idx;
        found = 1'b1;
      end
    end

    case (state)
      S_IDLE: begin
        if (found) begin
          state_n    = S_START;
          ack_n[win] = 1'b1;
          start_n    = 1'b1;
        end
      end
      S_START: state_n = S_WAIT;
      S_WAIT: begin
        if (word_end) begin
          state_n          = S_IDLE;
          done_n[grant_id] = 1'b1;
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

  // All outputs are registered; word_data changes only on a grant edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_IDLE;
      ack        <= '0;
      done       <= '0;
      word_start <= 1'b0;
      busy       <= 1'b0;
      word_data  <= '0;
      grant_id   <= '0;
      last       <= IDW'(NREQ - 1);
    end else begin
      state      <= state_n;
      ack        <= ack_n;
      done       <= done_n;
      word_start <= start_n;
      busy       <= (state_n != S_IDLE);
      if (start_n) begin
        word_data <= req_data[32*win +: 32];
        grant_id  <= win;
        last      <= win;
      end
    end
  end

endmodule
